// File: rtl/rgmii_pkg.sv
// Shared types and helpers for the RGMII receive-path IDELAY tuner.
// The tuner FSM state encoding and the window-centre arithmetic live here.
package rgmii_pkg;

    typedef enum logic [3:0] {
        WAIT_RDY,
        LOAD,
        SETTLE,
        IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEAS,
        S_NEXT,
        S_APPLY
    } tuner_state_e;

    localparam int RGMII_CTL_LANE = 4;

    // Centre of a window; rounds towards the start for even lengths.
    function automatic logic [15:0] tap_center(input logic [15:0] start,
                                               input logic [16:0] len);
        logic [16:0] half;
        half = (len - 17'd1) >> 1;
        return start + half[15:0];
    endfunction

endpackage

// File: rtl/rgmii_tap_scorer.sv
// Scores one sweep tap: counts WINDOW frames (or times out) and reports
// pass when every counted frame was error-free.
import rgmii_pkg::*;

module rgmii_tap_scorer #(
    parameter int WINDOW       = 8,
    parameter int MEAS_TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic frame_done,
    input  logic frame_err,
    output logic done,
    output logic pass
);

    localparam int FC_W = $clog2(WINDOW + 1);
    localparam int TO_W = $clog2(MEAS_TIMEOUT + 1);

    logic            active_q, active_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [FC_W-1:0] fcnt_nx;
    logic [TO_W-1:0] tcnt_nx;
    logic            err_nx;

    always_comb begin
        active_d = active_q;
        err_d    = err_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fcnt_d   = fcnt_q;
        tcnt_d   = tcnt_q;
        fcnt_nx  = fcnt_q + FC_W'(frame_done);
        tcnt_nx  = tcnt_q + TO_W'(1);
        err_nx   = err_q | (frame_done & frame_err);
        if (start) begin
            active_d = 1'b1;
            err_d    = 1'b0;
            fcnt_d   = '0;
            tcnt_d   = '0;
        end else if (active_q) begin
            fcnt_d = fcnt_nx;
            tcnt_d = tcnt_nx;
            err_d  = err_nx;
            if (fcnt_nx == FC_W'(WINDOW)) begin
                done_d   = 1'b1;
                pass_d   = !err_nx;
                active_d = 1'b0;
            end else if (tcnt_nx == TO_W'(MEAS_TIMEOUT)) begin
                // Too few frames seen: the tap cannot be trusted.
                done_d   = 1'b1;
                pass_d   = 1'b0;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fcnt_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            active_q <= active_d;
            err_q    <= err_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fcnt_q   <= fcnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: rtl/rgmii_idelay_tuner.sv
// Runtime IDELAYE2 (VAR_LOAD) tap controller for the RGMII rx lanes with
// manual per-lane writes and an automatic eye sweep that centres the taps.
import rgmii_pkg::*;

module rgmii_idelay_tuner #(
    parameter int LANES         = 5,
    parameter int TAP_W         = 5,
    parameter int DEFAULT_TAP   = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW        = 8,
    parameter int MEAS_TIMEOUT  = 1048576
) (
    input  logic                       clk_int,
    input  logic                       rst_int_n,
    input  logic                       idelayctrl_rdy,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       cfg_all,
    input  logic [$clog2(LANES)-1:0]   cfg_lane,
    input  logic [TAP_W-1:0]           cfg_tap,
    input  logic                       sweep_start,
    input  logic                       frame_done,
    input  logic                       frame_err,
    output logic [LANES-1:0]           idelay_ld,
    output logic [LANES*TAP_W-1:0]     idelay_cntvaluein,
    output logic                       busy,
    output logic                       locked,
    output logic                       sweep_fail,
    output logic [TAP_W-1:0]           best_tap,
    output logic [TAP_W:0]             best_len
);

    localparam int LANE_W = $clog2(LANES);
    localparam int RW     = TAP_W + 1;
    localparam int ST_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;
    localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);

    tuner_state_e     state_q, state_d;
    logic             rdy_meta_q, rdy_sync_q;
    logic [TAP_W-1:0] cnt_q [LANES];
    logic [TAP_W-1:0] cnt_d [LANES];
    logic [LANES-1:0] ld_mask_q, ld_mask_d;
    logic [LANES-1:0] idelay_ld_q;
    logic [LANES-1:0] lane_sel;
    logic [ST_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [RW-1:0]    run_q, run_d;
    logic [TAP_W-1:0] win_start_q, win_start_d;
    logic [RW-1:0]    win_len_q, win_len_d;
    logic [TAP_W-1:0] best_tap_q, best_tap_d;
    logic [RW-1:0]    best_len_q, best_len_d;
    logic             locked_q, locked_d;
    logic             sweep_fail_q, sweep_fail_d;
    logic             settle_last;
    logic             sc_start, sc_done, sc_pass;
    logic [TAP_W-1:0] center_tap;

    // IDELAYCTRL RDY arrives from another domain.
    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
        end else begin
            rdy_meta_q <= idelayctrl_rdy;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_sel[gi] = cfg_all || (cfg_lane == LANE_W'(gi));
            assign idelay_cntvaluein[gi*TAP_W +: TAP_W] = cnt_q[gi];
        end
    endgenerate

    assign settle_last = (settle_cnt_q == ST_W'(SETTLE_CYCLES - 1));
    assign sc_start    = (state_q == S_SETTLE) && settle_last && rdy_sync_q;
    assign cfg_ready   = (state_q == IDLE) && rdy_sync_q && !sweep_start;
    assign center_tap  = TAP_W'(tap_center(16'(win_start_q), 17'(win_len_q)));

    rgmii_tap_scorer #(
        .WINDOW       (WINDOW),
        .MEAS_TIMEOUT (MEAS_TIMEOUT)
    ) u_scorer (
        .clk        (clk_int),
        .rst_n      (rst_int_n),
        .start      (sc_start),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .done       (sc_done),
        .pass       (sc_pass)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_mask_d    = ld_mask_q;
        settle_cnt_d = '0;
        tap_d        = tap_q;
        run_d        = run_q;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        best_tap_d   = best_tap_q;
        best_len_d   = best_len_q;
        locked_d     = locked_q;
        sweep_fail_d = sweep_fail_q;
        if (state_q != WAIT_RDY && !rdy_sync_q) begin
            // Lost IDELAYCTRL: drop everything but keep taps and results.
            state_d  = WAIT_RDY;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_RDY: begin
                    if (rdy_sync_q) begin
                        for (int i = 0; i < LANES; i++) cnt_d[i] = DEF_TAP;
                        ld_mask_d = '1;
                        state_d   = LOAD;
                    end
                end
                LOAD:   state_d = SETTLE;
                SETTLE: begin
                    if (settle_last) begin
                        state_d  = IDLE;
                        locked_d = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + ST_W'(1);
                    end
                end
                IDLE: begin
                    if (sweep_start) begin
                        locked_d     = 1'b0;
                        sweep_fail_d = 1'b0;
                        tap_d        = '0;
                        run_d        = '0;
                        win_start_d  = '0;
                        win_len_d    = '0;
                        for (int i = 0; i < LANES; i++) cnt_d[i] = '0;
                        ld_mask_d    = '1;
                        state_d      = S_LOAD;
                    end else if (cfg_valid) begin
                        for (int i = 0; i < LANES; i++)
                            if (lane_sel[i]) cnt_d[i] = cfg_tap;
                        ld_mask_d = lane_sel;
                        state_d   = LOAD;
                    end
                end
                S_LOAD:   state_d = S_SETTLE;
                S_SETTLE: begin
                    if (settle_last) state_d = S_MEAS;
                    else             settle_cnt_d = settle_cnt_q + ST_W'(1);
                end
                S_MEAS: begin
                    if (sc_done) begin
                        run_d   = sc_pass ? run_q + RW'(1) : '0;
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Strict compare keeps the earliest of equal windows.
                    if (run_q > win_len_q) begin
                        win_len_d   = run_q;
                        win_start_d = TAP_W'({1'b0, tap_q} - run_q + RW'(1));
                    end
                    if (tap_q == TAP_MAX) begin
                        state_d = S_APPLY;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                        for (int i = 0; i < LANES; i++) cnt_d[i] = tap_q + TAP_W'(1);
                        state_d = S_LOAD;
                    end
                end
                S_APPLY: begin
                    if (win_len_q != '0) begin
                        best_tap_d = center_tap;
                        best_len_d = win_len_q;
                        for (int i = 0; i < LANES; i++) cnt_d[i] = center_tap;
                    end else begin
                        sweep_fail_d = 1'b1;
                        best_len_d   = '0;
                        for (int i = 0; i < LANES; i++) cnt_d[i] = DEF_TAP;
                    end
                    ld_mask_d = '1;
                    state_d   = LOAD;
                end
                default: state_d = WAIT_RDY;
            endcase
        end
    end

    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= WAIT_RDY;
            for (int i = 0; i < LANES; i++) cnt_q[i] <= DEF_TAP;
            ld_mask_q    <= '0;
            idelay_ld_q  <= '0;
            settle_cnt_q <= '0;
            tap_q        <= '0;
            run_q        <= '0;
            win_start_q  <= '0;
            win_len_q    <= '0;
            best_tap_q   <= '0;
            best_len_q   <= '0;
            locked_q     <= 1'b0;
            sweep_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_mask_q    <= ld_mask_d;
            // LD follows the value register by a full cycle.
            idelay_ld_q  <= ((state_q == LOAD || state_q == S_LOAD) && rdy_sync_q)
                            ? ld_mask_q : '0;
            settle_cnt_q <= settle_cnt_d;
            tap_q        <= tap_d;
            run_q        <= run_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
            best_tap_q   <= best_tap_d;
            best_len_q   <= best_len_d;
            locked_q     <= locked_d;
            sweep_fail_q <= sweep_fail_d;
        end
    end

    assign idelay_ld  = idelay_ld_q;
    assign busy       = (state_q != IDLE);
    assign locked     = locked_q;
    assign sweep_fail = sweep_fail_q;
    assign best_tap   = best_tap_q;
    assign best_len   = best_len_q;

endmodule

// File: tb/tb_rgmii_idelay_tuner.sv
// Scoreboard bench for rgmii_idelay_tuner: expected LD pulses are queued by
// the stimulus and checked by an independent monitor on every LD event.
module tb_rgmii_idelay_tuner;

    localparam int LANES = 5;
    localparam int TAP_W = 5;

    logic                   clk_int = 1'b0;
    logic                   rst_int_n;
    logic                   idelayctrl_rdy;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_all;
    logic [2:0]             cfg_lane;
    logic [TAP_W-1:0]       cfg_tap;
    logic                   sweep_start;
    logic                   frame_done;
    logic                   frame_err;
    logic [LANES-1:0]       idelay_ld;
    logic [LANES*TAP_W-1:0] idelay_cntvaluein;
    logic                   busy;
    logic                   locked;
    logic                   sweep_fail;
    logic [TAP_W-1:0]       best_tap;
    logic [TAP_W:0]         best_len;

    always #4 clk_int = ~clk_int;

    rgmii_idelay_tuner #(
        .LANES         (LANES),
        .TAP_W         (TAP_W),
        .DEFAULT_TAP   (0),
        .SETTLE_CYCLES (16),
        .WINDOW        (8),
        .MEAS_TIMEOUT  (64)
    ) dut (
        .clk_int           (clk_int),
        .rst_int_n         (rst_int_n),
        .idelayctrl_rdy    (idelayctrl_rdy),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_all           (cfg_all),
        .cfg_lane          (cfg_lane),
        .cfg_tap           (cfg_tap),
        .sweep_start       (sweep_start),
        .frame_done        (frame_done),
        .frame_err         (frame_err),
        .idelay_ld         (idelay_ld),
        .idelay_cntvaluein (idelay_cntvaluein),
        .busy              (busy),
        .locked            (locked),
        .sweep_fail        (sweep_fail),
        .best_tap          (best_tap),
        .best_len          (best_len)
    );

    typedef struct packed {
        logic [4:0]  mask;
        logic [24:0] taps;
    } ld_t;

    ld_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  mode     = 0;
    int  fcyc     = 0;
    bit  mon_en   = 1'b0;
    ld_t mon_e;

    function automatic logic [24:0] all_lanes(input logic [4:0] t);
        return {5{t}};
    endfunction

    function automatic bit tap_ok(input int m, input int t);
        case (m)
            1:       return (t >= 10 && t <= 21);
            2:       return (t >= 3 && t <= 5) || (t >= 20 && t <= 22);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk_int);
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every LD pulse must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk_int);
            if (mon_en && idelay_ld !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ld actual=0x%0h required=none", idelay_ld);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("ld mask=0x%0h taps=0x%0h", idelay_ld, idelay_cntvaluein);
                    chk("ld_mask", 32'(idelay_ld), 32'(mon_e.mask));
                    chk("ld_taps", 32'(idelay_cntvaluein), 32'(mon_e.taps));
                end
            end
        end
    end

    // Frame source: one frame every 4 cycles, error set by the eye model.
    initial begin
        frame_done = 1'b0;
        frame_err  = 1'b0;
        forever begin
            @(negedge clk_int);
            fcyc++;
            frame_done = (mode != 0) && (fcyc % 4 == 0);
            frame_err  = frame_done && !tap_ok(mode, int'(idelay_cntvaluein[4:0]));
        end
    end

    task automatic do_sweep(input int m, input logic [4:0] exp_best,
                            input logic [5:0] exp_len, input bit exp_fail,
                            input string tag);
        logic [4:0] final_tap;
        final_tap = exp_fail ? 5'd0 : exp_best;
        mode = m;
        for (int t = 0; t < 32; t++) exp_q.push_back({5'h1f, all_lanes(5'(t))});
        exp_q.push_back({5'h1f, all_lanes(final_tap)});
        @(negedge clk_int);
        sweep_start = 1'b1;
        cfg_valid   = 1'b1;
        cfg_all     = 1'b1;
        cfg_tap     = 5'd9;
        #1;
        chk({tag, "_cfg_ready_vs_start"}, 32'(cfg_ready), 32'd0);
        @(negedge clk_int);
        sweep_start = 1'b0;
        cfg_valid   = 1'b0;
        chk({tag, "_locked_during"}, 32'(locked), 32'd0);
        wait_idle(20000, tag);
        $display("sweep %s best_tap=%0d best_len=%0d fail=%0d", tag, best_tap, best_len, sweep_fail);
        chk({tag, "_locked"}, 32'(locked), 32'd1);
        chk({tag, "_sweep_fail"}, 32'(sweep_fail), 32'(exp_fail));
        chk({tag, "_best_tap"}, 32'(best_tap), 32'(exp_best));
        chk({tag, "_best_len"}, 32'(best_len), 32'(exp_len));
        chk({tag, "_lanes"}, 32'(idelay_cntvaluein), 32'(all_lanes(final_tap)));
        chk({tag, "_all_lds_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_int_n      = 1'b1;
        idelayctrl_rdy = 1'b0;
        cfg_valid      = 1'b0;
        cfg_all        = 1'b0;
        cfg_lane       = '0;
        cfg_tap        = '0;
        sweep_start    = 1'b0;
        #2 rst_int_n = 1'b0;
        repeat (3) @(negedge clk_int);
        chk("rst_ld", 32'(idelay_ld), 32'd0);
        chk("rst_taps", 32'(idelay_cntvaluein), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_results", {sweep_fail, best_tap, best_len}, 32'd0);
        rst_int_n = 1'b1;
        mon_en    = 1'b1;

        // Power-up: default taps loaded once RDY is seen.
        exp_q.push_back({5'h1f, all_lanes(5'd0)});
        repeat (10) @(negedge clk_int);
        idelayctrl_rdy = 1'b1;
        repeat (3) @(negedge clk_int);
        chk("pre_lock_locked", 32'(locked), 32'd0);
        wait_idle(200, "powerup");
        chk("powerup_locked", 32'(locked), 32'd1);
        chk("powerup_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("powerup_lds_seen", 32'(exp_q.size()), 32'd0);

        // Manual single-lane write.
        exp_q.push_back({5'b00100, 25'(13) << 10});
        @(negedge clk_int);
        cfg_valid = 1'b1;
        cfg_all   = 1'b0;
        cfg_lane  = 3'd2;
        cfg_tap   = 5'd13;
        #1;
        chk("man_cfg_ready_idle", 32'(cfg_ready), 32'd1);
        @(negedge clk_int);
        cfg_valid = 1'b0;
        chk("man_cfg_ready_busy", 32'(cfg_ready), 32'd0);
        chk("man_locked_kept", 32'(locked), 32'd1);
        repeat (10) @(negedge clk_int);
        chk("man_cfg_ready_settle", 32'(cfg_ready), 32'd0);
        wait_idle(200, "manual");
        chk("man_lanes", 32'(idelay_cntvaluein), 32'(25'(13) << 10));
        chk("man_cfg_ready_done", 32'(cfg_ready), 32'd1);

        // Broadcast write.
        exp_q.push_back({5'h1f, all_lanes(5'd6)});
        @(negedge clk_int);
        cfg_valid = 1'b1;
        cfg_all   = 1'b1;
        cfg_lane  = 3'd0;
        cfg_tap   = 5'd6;
        @(negedge clk_int);
        cfg_valid = 1'b0;
        cfg_all   = 1'b0;
        wait_idle(200, "bcast");
        chk("bcast_lanes", 32'(idelay_cntvaluein), 32'(all_lanes(5'd6)));

        do_sweep(1, 5'd15, 6'd12, 1'b0, "win10_21");
        do_sweep(2, 5'd4, 6'd3, 1'b0, "equal_windows");

        // Abort at tap 7 by dropping RDY mid-measurement.
        mode = 1;
        for (int t = 0; t < 8; t++) exp_q.push_back({5'h1f, all_lanes(5'(t))});
        @(negedge clk_int);
        sweep_start = 1'b1;
        @(negedge clk_int);
        sweep_start = 1'b0;
        n = 0;
        while (!(idelay_ld !== '0 && idelay_cntvaluein[4:0] == 5'd7) && n < 5000) begin
            @(negedge clk_int);
            n++;
        end
        chk("abort_reach_tap7", 32'(n < 5000), 32'd1);
        repeat (26) @(negedge clk_int);
        idelayctrl_rdy = 1'b0;
        repeat (6) @(negedge clk_int);
        chk("abort_locked", 32'(locked), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_taps_held", 32'(idelay_cntvaluein), 32'(all_lanes(5'd7)));
        repeat (30) @(negedge clk_int);
        chk("abort_best_tap", 32'(best_tap), 32'd4);
        chk("abort_best_len", 32'(best_len), 32'd3);
        chk("abort_lds_seen", 32'(exp_q.size()), 32'd0);
        exp_q.push_back({5'h1f, all_lanes(5'd0)});
        idelayctrl_rdy = 1'b1;
        repeat (3) @(negedge clk_int);
        wait_idle(200, "reload");
        chk("reload_locked", 32'(locked), 32'd1);
        chk("reload_lanes", 32'(idelay_cntvaluein), 32'd0);
        chk("reload_best", {best_tap, best_len}, {21'd0, 5'd4, 6'd3});
        chk("reload_lds_seen", 32'(exp_q.size()), 32'd0);

        do_sweep(3, 5'd4, 6'd0, 1'b1, "all_err");
        do_sweep(0, 5'd4, 6'd0, 1'b1, "timeout");

        repeat (5) @(negedge clk_int);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_idelay_tuner.md
Name: rgmii_idelay_tuner

Overview:
- Runtime controller for the RGMII receive-path IDELAYE2 lanes (rxd[3:0] plus rx_ctl) in VAR_LOAD mode. Replaces fixed-tap delays with per-lane programmable taps.
- Adds an automatic eye sweep: steps a broadcast tap across the full range, scores each tap by receive-frame errors, then loads the centre of the widest passing window.
- Sits in the RGMII SoC wrapper between IDELAYCTRL/IDELAYE2 primitives and the host status/config path, clocked by the IDELAYE2 C clock.

Parameters:
LANES, 5, number of delay lanes (lane LANES-1 = rx_ctl)
TAP_W, 5, tap value width; tap range 0..2^TAP_W-1
DEFAULT_TAP, 0, tap loaded after reset and after a failed sweep
SETTLE_CYCLES, 16, clk_int cycles to wait after each LD pulse
WINDOW, 8, frames scored per tap during a sweep
MEAS_TIMEOUT, 1048576, cycles without WINDOW frames before a tap is scored as fail

Ports:
clk_int  in  1  125 MHz clock; also drives IDELAYE2 C
rst_int_n  in  1  asynchronous active-low reset
idelayctrl_rdy  in  1  IDELAYCTRL RDY; asynchronous, 2-flop synchronised internally
cfg_valid  in  1  manual tap write request
cfg_ready  out  1  manual write accepted when valid&&ready
cfg_all  in  1  1 = write cfg_tap to all lanes, ignore cfg_lane
cfg_lane  in  $clog2(LANES)  target lane
cfg_tap  in  TAP_W  tap value
sweep_start  in  1  single-cycle pulse; starts an automatic sweep
frame_done  in  1  single-cycle pulse at the end of each received frame
frame_err  in  1  qualifies frame_done; 1 = FCS/PHY error
idelay_ld  out  LANES  per-lane LD to IDELAYE2
idelay_cntvaluein  out  LANES*TAP_W  per-lane CNTVALUEIN; lane i occupies bits [i*TAP_W +: TAP_W]
busy  out  1  not in IDLE
locked  out  1  taps valid and stable
sweep_fail  out  1  last sweep found no passing tap
best_tap  out  TAP_W  tap chosen by the last successful sweep
best_len  out  TAP_W+1  width of the passing window from the last sweep

Behaviour:
- Reset values: idelay_ld=0; all lanes of idelay_cntvaluein=DEFAULT_TAP; cfg_ready=0; busy=1; locked=0; sweep_fail=0; best_tap=0; best_len=0; state=WAIT_RDY.
- FSM states: WAIT_RDY, LOAD, SETTLE, IDLE, S_LOAD, S_SETTLE, S_MEAS, S_NEXT, S_APPLY.
- WAIT_RDY: on synchronised rdy=1, drive DEFAULT_TAP to all lanes, then go to LOAD.
- LOAD:
  - idelay_ld is high for exactly 1 cycle on the target lanes.
  - cntvaluein is registered one cycle before LD and held stable until the next load.
- SETTLE: count SETTLE_CYCLES, then go to IDLE with locked=1.
- IDLE:
  - cfg_ready = !sweep_start.
  - Accepted cfg updates the target lane(s) only, then LOAD→SETTLE→IDLE.
  - locked stays 1 through a manual load.
  - sweep_start has priority over cfg_valid in the same cycle.
- Sweep:
  - On start: locked=0, sweep_fail=0, t=0, run length and best window cleared.
  - S_LOAD: load t to all lanes, then S_SETTLE.
  - S_MEAS:
    - Count frame_done pulses and OR frame_err into a fail flag.
    - Frame events during LOAD/SETTLE are ignored.
    - Exit after WINDOW frames, or when MEAS_TIMEOUT expires (timeout scores the tap as fail).
  - S_NEXT:
    - Pass extends the current run. Fail resets the run to 0.
    - If run > best_len, record best_start = t-run+1 and best_len = run. Strictly greater, so the earliest of equal windows wins.
    - If t == 2^TAP_W-1, go to S_APPLY. Otherwise t++ and go to S_LOAD.
    - The tap counter does not wrap.
  - S_APPLY:
    - best_len>0: best_tap = best_start + (best_len-1)>>1; load it to all lanes; locked=1 after settle.
    - best_len==0: sweep_fail=1; load DEFAULT_TAP; locked=1.
- Outside IDLE: cfg_ready=0, and sweep_start is ignored.
- rdy falls in any state other than WAIT_RDY:
  - Abort to WAIT_RDY: locked=0, idelay_ld=0.
  - A sweep in progress is abandoned; best_* keep their previous values.
  - cntvaluein is held.
- Reset mid-operation returns to reset values immediately (asynchronous).
- Counters use saturating-free widths: frame counter $clog2(WINDOW+1) bits, timeout counter $clog2(MEAS_TIMEOUT+1) bits, run/best_len TAP_W+1 bits (a full 2^TAP_W run is representable).

Decomposition:
- Package rgmii_pkg holds:
  - the state enum tuner_state_e
  - the lane index constant RGMII_CTL_LANE = 4
  - the function tap_center(start,len)
- One natural sub-module: rgmii_tap_scorer.
  - Owns the frame/timeout counters and the pass/fail verdict.
  - Interface: start, frame_done, frame_err, done, pass.
- Synchroniser: existing 2-flop sync cell.

Test Plan:
- Reset release, rdy rises at cycle 10 → sync delay, one 5-lane LD pulse with taps=0, locked=1 after 16 settle cycles; cfg_ready=1.
- Manual write cfg_lane=2, cfg_tap=13 → only idelay_ld[2] pulses, lane2 field=13, other lanes unchanged, cfg_ready low until settle completes.
- Sweep, error model fails taps 0–9 and 22–31, passes 10–21 (8 clean frames each) → best_len=12, best_tap=15, all lanes=15, sweep_fail=0.
- Sweep, passing windows 3–5 and 20–22 (equal length) → best_tap=4 (earliest window).
- Sweep with every tap erroring, and also with no frame_done (timeout) → sweep_fail=1, all lanes=DEFAULT_TAP, locked=1.
- rdy deasserted during S_MEAS at tap 7 → state WAIT_RDY, locked=0, no LD pulses until rdy returns; then default reload; best_* unchanged.
